// File: rtl/pipe_sub8_pkg.sv
// Shared constants for the pipelined ripple-borrow subtractor.
package pipe_sub8_pkg;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned LATENCY = WIDTH + 1;

endpackage

// File: rtl/mysub1.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module mysub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/pipe_sub8.sv
// Pipelined ripple-borrow subtractor, one bit per stage: D = A - B, BOUT = (A < B).
// Register ranks: capture, WIDTH borrow stages, output (WIDTH+2 in total).
// Optional macro SUB_OVF_EN adds the signed-overflow output OVF.
module pipe_sub8
  import pipe_sub8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
`ifdef SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  // vld_r[0] is the capture rank; vld_r[k+1] is the rank after stage k
  logic [WIDTH:0]   vld_r;
  // opa_r/opb_r[k] are the operands seen by stage k (index 0 = capture)
  logic [WIDTH-1:0] opa_r [WIDTH];
  logic [WIDTH-1:0] opb_r [WIDTH];
  // brw_r[k] and dif_r[k] hold the borrow and partial difference after stage k
  logic [WIDTH-1:0] brw_r;
  logic [WIDTH-1:0] dif_r [WIDTH];

  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic [WIDTH-1:0] bin_c;
  logic [WIDTH-1:0] d_c;
  logic [WIDTH-1:0] bo_c;

`ifdef SUB_OVF_EN
  logic sa_r;
  logic sb_r;
`endif

  // Pick operand bit k out of the operand copy travelling alongside stage k
  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int k = 0; k < WIDTH; k++) begin
      a_c[k] = opa_r[k][k];
      b_c[k] = opb_r[k][k];
    end
  end

  // Stage 0 has no incoming borrow; stage k takes the registered borrow of stage k-1
  assign bin_c = {brw_r[WIDTH-2:0], 1'b0};

  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    mysub1 u_sub (
      .a    (a_c[k]),
      .b    (b_c[k]),
      .bin  (bin_c[k]),
      .d    (d_c[k]),
      .bout (bo_c[k])
    );
  end

  // Capture rank plus all borrow stages advance together when en is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      brw_r <= '0;
      for (int k = 0; k < WIDTH; k++) begin
        opa_r[k] <= '0;
        opb_r[k] <= '0;
        dif_r[k] <= '0;
      end
    end else if (en) begin
      vld_r    <= {vld_r[WIDTH-1:0], in_valid};
      opa_r[0] <= A;
      opb_r[0] <= B;
      for (int k = 1; k < WIDTH; k++) begin
        opa_r[k] <= opa_r[k-1];
        opb_r[k] <= opb_r[k-1];
      end
      brw_r    <= bo_c;
      dif_r[0] <= WIDTH'(d_c[0]);
      for (int k = 1; k < WIDTH; k++) begin
        dif_r[k] <= dif_r[k-1] | (WIDTH'(d_c[k]) << k);
      end
    end
  end

`ifdef SUB_OVF_EN
  // Sign bits of the operands ride alongside the last borrow stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_r <= 1'b0;
      sb_r <= 1'b0;
    end else if (en) begin
      sa_r <= opa_r[WIDTH-1][WIDTH-1];
      sb_r <= opb_r[WIDTH-1][WIDTH-1];
    end
  end
`endif

  // Output rank: completed difference, final borrow and valid tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      D         <= '0;
      BOUT      <= 1'b0;
`ifdef SUB_OVF_EN
      OVF       <= 1'b0;
`endif
    end else if (en) begin
      out_valid <= vld_r[WIDTH];
      D         <= dif_r[WIDTH-1];
      BOUT      <= brw_r[WIDTH-1];
`ifdef SUB_OVF_EN
      OVF       <= (sa_r ^ sb_r) & (dif_r[WIDTH-1][WIDTH-1] ^ sa_r);
`endif
    end
  end

endmodule

// File: tb/tb_pipe_sub8.sv
// Scoreboard bench for pipe_sub8 (optionally built with SUB_OVF_EN).
module tb_pipe_sub8;
  import pipe_sub8_pkg::*;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    int unsigned      tag;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic [WIDTH-1:0] D;
  logic             BOUT;
`ifdef SUB_OVF_EN
  logic             OVF;
`endif

  exp_t        q[$];
  exp_t        push_e;
  exp_t        mon_e;
  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;
  int unsigned n_edge = 0;
  bit          edge_en = 1'b0;

  logic             snap_v;
  logic [WIDTH-1:0] snap_d;
  logic             snap_b;

  pipe_sub8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .D         (D),
    .BOUT      (BOUT)
`ifdef SUB_OVF_EN
    ,
    .OVF       (OVF)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Push the expected result of every operand pair accepted on an enabled edge
  always @(posedge clk) begin
    edge_en = rst_n && en;
    if (edge_en) begin
      n_edge++;
      if (in_valid) begin
        push_e.d    = WIDTH'(A - B);
        push_e.bout = (A < B);
        push_e.ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (push_e.d[WIDTH-1] != A[WIDTH-1]);
        push_e.tag  = n_edge;
        q.push_back(push_e);
      end
    end
  end

  // After each enabled edge, compare the output rank against the scoreboard
  always @(negedge clk) begin
    if (edge_en && rst_n) begin
      if (q.size() == 0) begin
        check_eq("idle_valid", 32'(out_valid), 32'(0));
      end else if (out_valid) begin
        mon_e = q.pop_front();
        check_eq("D", 32'(D), 32'(mon_e.d));
        check_eq("BOUT", 32'(BOUT), 32'(mon_e.bout));
        check_eq("latency", 32'(n_edge - mon_e.tag), 32'(LATENCY));
`ifdef SUB_OVF_EN
        check_eq("OVF", 32'(OVF), 32'(mon_e.ovf));
`endif
      end else begin
        check_eq("late_result", 32'((n_edge - q[0].tag) < LATENCY), 32'(1));
      end
    end
  end

  task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic v, input logic e);
    A        = a;
    B        = b;
    in_valid = v;
    en       = e;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) step('0, '0, 1'b0, 1'b1);
    check_eq("drain_empty", 32'(q.size()), 32'(0));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'(0));
    check_eq({tag, "_D"}, 32'(D), 32'(0));
    check_eq({tag, "_BOUT"}, 32'(BOUT), 32'(0));
`ifdef SUB_OVF_EN
    check_eq({tag, "_OVF"}, 32'(OVF), 32'(0));
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single operand pair
    step(8'h05, 8'h03, 1'b1, 1'b1);
    drain();

    // Borrow wrap and equal operands
    step(8'h00, 8'h01, 1'b1, 1'b1);
    step(8'hFF, 8'hFF, 1'b1, 1'b1);
    drain();

    // Signed-overflow corner cases
    step(8'h80, 8'h01, 1'b1, 1'b1);
    step(8'h7F, 8'hFF, 1'b1, 1'b1);
    step(8'h05, 8'h03, 1'b1, 1'b1);
    drain();

    // Back-to-back stream, then one bubble carrying junk operands
    for (int i = 0; i < 20; i++) step(8'(i + 10), 8'(i), 1'b1, 1'b1);
    step(8'h33, 8'h44, 1'b0, 1'b1);
    step(8'h40, 8'h01, 1'b1, 1'b1);
    step(8'h41, 8'h02, 1'b1, 1'b1);
    drain();

    // Stall mid-stream with junk on the inputs
    for (int i = 0; i < 12; i++) step(8'($urandom), 8'($urandom), 1'b1, 1'b1);
    snap_v = out_valid;
    snap_d = D;
    snap_b = BOUT;
    for (int i = 0; i < 3; i++) begin
      step(8'($urandom), 8'($urandom), 1'b1, 1'b0);
      check_eq("stall_valid", 32'(out_valid), 32'(snap_v));
      check_eq("stall_D", 32'(D), 32'(snap_d));
      check_eq("stall_BOUT", 32'(BOUT), 32'(snap_b));
    end
    for (int i = 0; i < 6; i++) step(8'($urandom), 8'($urandom), 1'b1, 1'b1);
    drain();

    // Reset between edges with results in flight and at the output
    for (int i = 0; i < 14; i++) step(8'(i + 10), 8'(i), 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("midrst");
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step('0, '0, 1'b0, 1'b1);
    step(8'h22, 8'h11, 1'b1, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
